data_memory_manager_mp: RTL and testbench

Parametrised successor of the data-memory/IO manager. It owns the data address register, an internal synchronous data RAM, and N memory-mapped input/output port pairs at the top of the address space. Compared with the previous generation it adds auto-increment addressing, registered reads with a valid strobe, synchronised input ports, reset output ports and an access-error pulse. It sits between the CPU datapath and the board IO.

---
 rtl/data_memory_manager_mp.sv | 132 +++++++++++++
 tb/tb_data_memory_manager_mp.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_manager_mp.sv
// Data memory / IO manager: address register with auto-increment, internal
// data RAM, and N memory-mapped IO port pairs at the top of the address space.
// Output port i sits at TOP-2i and input port i at TOP-1-2i. RAM fills
// everything below the port window. Reads are registered and flagged by
// out_valid. Illegal accesses raise a one-cycle out_err pulse.
module data_memory_manager_mp #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int PORT_W  = 4,
  parameter int N_PORTS = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_addr_write_en,
  input  logic                        in_addr_inc,
  input  logic [ADDR_W-1:0]           in_addr,
  input  logic                        in_write_en,
  input  logic                        in_read_en,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [N_PORTS*PORT_W-1:0]   in_port,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  output logic [N_PORTS*PORT_W-1:0]   out_port,
  output logic                        out_err
);

  localparam int                RAM_DEPTH = (1 << ADDR_W) - 2 * N_PORTS;
  localparam int                PW        = N_PORTS * PORT_W;
  localparam logic [ADDR_W-1:0] TOP       = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] RAM_TOP   = ADDR_W'(RAM_DEPTH - 1);

  logic [ADDR_W-1:0] addr_r;
  logic [PW-1:0]     sync1_r;
  logic [PW-1:0]     sync2_r;
  logic [PW-1:0]     out_port_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              out_err_r;
  logic [DATA_W-1:0] mem [0:RAM_DEPTH-1];

  logic              is_ram_s;
  logic              is_in_s;
  logic              is_out_s;
  logic [ADDR_W-1:0] offset_s;
  logic [ADDR_W-1:0] port_idx_s;
  logic [DATA_W-1:0] in_val_s;
  logic [DATA_W-1:0] out_val_s;
  logic [DATA_W-1:0] rd_val_s;
  logic              rd_ok_s;
  logic              err_s;

  // Decode the held address into RAM / input port / output port and select read data
  always_comb begin
    is_ram_s   = (addr_r <= RAM_TOP);
    offset_s   = TOP - addr_r;
    port_idx_s = offset_s >> 1;
    is_in_s    = !is_ram_s && offset_s[0];
    is_out_s   = !is_ram_s && !offset_s[0];
    in_val_s   = '0;
    out_val_s  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (port_idx_s == ADDR_W'(i)) begin
        in_val_s[PORT_W-1:0]  = sync2_r[i*PORT_W +: PORT_W];
        out_val_s[PORT_W-1:0] = out_port_r[i*PORT_W +: PORT_W];
      end else begin
        in_val_s  = in_val_s;
        out_val_s = out_val_s;
      end
    end
    if (is_ram_s) begin
      rd_val_s = mem[addr_r];
    end else if (is_in_s) begin
      rd_val_s = in_val_s;
    end else begin
      rd_val_s = out_val_s;
    end
    rd_ok_s = in_read_en && !in_write_en;
    if (in_write_en && in_read_en) begin
      err_s = 1'b1;
    end else if (in_write_en && is_in_s) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (in_write_en && is_ram_s) begin
      mem[addr_r] <= in_data;
    end
  end

  // Address register, input synchronisers, output ports and registered read/error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= '0;
      sync1_r     <= '0;
      sync2_r     <= '0;
      out_port_r  <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_err_r   <= 1'b0;
    end else begin
      if (in_addr_write_en) begin
        addr_r <= in_addr;
      end else if (in_addr_inc) begin
        addr_r <= addr_r + ADDR_W'(1);
      end
      sync1_r <= in_port;
      sync2_r <= sync1_r;
      if (in_write_en && is_out_s) begin
        for (int i = 0; i < N_PORTS; i++) begin
          if (port_idx_s == ADDR_W'(i)) begin
            out_port_r[i*PORT_W +: PORT_W] <= in_data[PORT_W-1:0];
          end
        end
      end
      if (rd_ok_s) begin
        out_data_r <= rd_val_s;
      end
      out_valid_r <= rd_ok_s;
      out_err_r   <= err_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_port  = out_port_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_data_memory_manager_mp.sv
// Directed self-checking bench for data_memory_manager_mp with two port pairs.
// Map with N_PORTS=2: out0=1023, in0=1022, out1=1021, in1=1020, RAM 0..1019.
module tb_data_memory_manager_mp;

  logic        clk;
  logic        rst_n;
  logic        in_addr_write_en;
  logic        in_addr_inc;
  logic [9:0]  in_addr;
  logic        in_write_en;
  logic        in_read_en;
  logic [7:0]  in_data;
  logic [7:0]  in_port;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [7:0]  out_port;
  logic        out_err;

  int checks;
  int errors;

  data_memory_manager_mp #(
    .ADDR_W(10), .DATA_W(8), .PORT_W(4), .N_PORTS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_addr_write_en(in_addr_write_en), .in_addr_inc(in_addr_inc),
    .in_addr(in_addr), .in_write_en(in_write_en), .in_read_en(in_read_en),
    .in_data(in_data), .in_port(in_port),
    .out_data(out_data), .out_valid(out_valid),
    .out_port(out_port), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic aw, input logic inc, input logic [9:0] a,
                       input logic we, input logic re, input logic [7:0] d);
    in_addr_write_en = aw;
    in_addr_inc      = inc;
    in_addr          = a;
    in_write_en      = we;
    in_read_en       = re;
    in_data          = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_port = 8'($urandom);
    drive(1'b1, 1'b1, 10'($urandom), 1'b1, 1'b1, 8'($urandom));
    cyc();
    drive(1'b0, 1'b1, 10'($urandom), 1'b0, 1'b1, 8'($urandom));
    cyc();
    checks++;
    if ({out_data, out_valid, out_port, out_err} !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h valid=%b port=%h err=%b, want all 0",
               out_data, out_valid, out_port, out_err);
    end
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 8'h00);
    in_port = 8'h00;
    rst_n = 1'b1;
    // No load since reset: write then read must hit address 0
    drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 8'h77);
    cyc();
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 8'h00);
    cyc();
    checks++;
    if (out_data !== 8'h77 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_addr0: data=%h valid=%b, want 77/1", out_data, out_valid);
    end
  endtask

  task automatic test_ram_round_trip();
    drive(1'b1, 1'b0, 10'd5, 1'b0, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 8'hA5);
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_after_write: valid=%b, want 0", out_valid);
    end
    // Load 9 and read in the same cycle: read must still use address 5
    drive(1'b1, 1'b0, 10'd9, 1'b0, 1'b1, 8'h00);
    cyc();
    checks++;
    if (out_data !== 8'hA5 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ram_rt_old_addr: data=%h valid=%b, want a5/1", out_data, out_valid);
    end
    drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 8'h3E);
    cyc();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL data_hold: data=%h valid=%b, want a5/0", out_data, out_valid);
    end
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 8'h00);
    cyc();
    checks++;
    if (out_data !== 8'h3E || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL raw_addr9: data=%h valid=%b, want 3e/1", out_data, out_valid);
    end
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 8'h00);
    cyc();
  endtask

  task automatic test_auto_inc();
    drive(1'b1, 1'b0, 10'd1019, 1'b0, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 8'h11);
    cyc();
    checks++;
    if (out_err !== 1'b0) begin
      errors++;
      $display("FAIL burst_ram_err: err=%b, want 0", out_err);
    end
    // Second write lands on input port 1 (1020)
    drive(1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 8'h22);
    cyc();
    checks++;
    if (out_err !== 1'b1) begin
      errors++;
      $display("FAIL burst_inport_err: err=%b, want 1", out_err);
    end
    drive(1'b1, 1'b0, 10'd1019, 1'b0, 1'b0, 8'h00);
    cyc();
    checks++;
    if (out_err !== 1'b0 || out_port !== 8'h00) begin
      errors++;
      $display("FAIL err_pulse: err=%b port=%h, want 0/00", out_err, out_port);
    end
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 8'h00);
    cyc();
    checks++;
    if (out_data !== 8'h11 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL burst_ram1019: data=%h valid=%b, want 11/1", out_data, out_valid);
    end
    drive(1'b1, 1'b0, 10'd1023, 1'b0, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 8'h00);
    cyc();
    checks++;
    if (out_data !== 8'h77 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_to_0: data=%h valid=%b, want 77/1", out_data, out_valid);
    end
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 8'h00);
    cyc();
  endtask

  task automatic test_ports();
    drive(1'b1, 1'b0, 10'd1023, 1'b0, 1'b0, 8'h00);
    cyc();
    drive(1'b1, 1'b0, 10'd1021, 1'b1, 1'b0, 8'h3C);
    cyc();
    checks++;
    if (out_port !== 8'h0C) begin
      errors++;
      $display("FAIL outport0: port=%h, want 0c", out_port);
    end
    drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 8'h07);
    in_port = 8'h09;
    cyc();
    checks++;
    if (out_port !== 8'h7C || out_err !== 1'b0) begin
      errors++;
      $display("FAIL outport1: port=%h err=%b, want 7c/0", out_port, out_err);
    end
    drive(1'b1, 1'b0, 10'd1022, 1'b0, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 8'h00);
    cyc();
    checks++;
    if (out_data !== 8'h09 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL inport0: data=%h valid=%b, want 09/1", out_data, out_valid);
    end
    // Port 1 change: not visible to a read one edge later, visible two edges later
    in_port = 8'h59;
    drive(1'b1, 1'b0, 10'd1020, 1'b0, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 8'h00);
    cyc();
    checks++;
    if (out_data !== 8'h00 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL inport1_early: data=%h valid=%b, want 00/1", out_data, out_valid);
    end
    cyc();
    checks++;
    if (out_data !== 8'h05 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL inport1_synced: data=%h valid=%b, want 05/1", out_data, out_valid);
    end
    drive(1'b1, 1'b0, 10'd1023, 1'b0, 1'b0, 8'h00);
    cyc();
    drive(1'b1, 1'b0, 10'd1021, 1'b0, 1'b1, 8'h00);
    cyc();
    checks++;
    if (out_data !== 8'h0C || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_out0: data=%h valid=%b, want 0c/1", out_data, out_valid);
    end
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 8'h00);
    cyc();
    checks++;
    if (out_data !== 8'h07 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_out1: data=%h valid=%b, want 07/1", out_data, out_valid);
    end
  endtask

  task automatic test_conflict();
    drive(1'b1, 1'b0, 10'd8, 1'b0, 1'b0, 8'h00);
    cyc();
    drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 8'h5A);
    cyc();
    checks++;
    if (out_valid !== 1'b0 || out_err !== 1'b1 || out_data !== 8'h07) begin
      errors++;
      $display("FAIL conflict: valid=%b err=%b data=%h, want 0/1/07",
               out_valid, out_err, out_data);
    end
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 8'h00);
    cyc();
    checks++;
    if (out_err !== 1'b0 || out_data !== 8'h5A || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL conflict_write: err=%b data=%h valid=%b, want 0/5a/1",
               out_err, out_data, out_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    drive(1'b1, 1'b0, 10'd8, 1'b0, 1'b1, 8'h00);
    cyc();
    drive(1'b0, 1'b1, 10'd0, 1'b0, 1'b1, 8'h00);
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_data, out_valid, out_port, out_err} !== 18'h0) begin
      errors++;
      $display("FAIL reset_async: data=%h valid=%b port=%h err=%b, want all 0",
               out_data, out_valid, out_port, out_err);
    end
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 8'h00);
    cyc();
    rst_n = 1'b1;
    // Address register back at 0: write there, then read via explicit load 0
    drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 8'h66);
    cyc();
    drive(1'b1, 1'b0, 10'd0, 1'b0, 1'b1, 8'h00);
    cyc();
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 8'h00);
    cyc();
    checks++;
    if (out_data !== 8'h66 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_addr_cleared: data=%h valid=%b, want 66/1", out_data, out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ram_round_trip();
    test_auto_inc();
    test_ports();
    test_conflict();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
